// File: rtl/reorder_buffer_pkg.sv
// Shared constants and types for the reorder buffer slice.
// Optional build macro REORDER_BUFFER_FWD_EN (used in rob_query_mux) adds
// same-cycle writeback bypass to the operand queries.
package reorder_buffer_pkg;

  localparam int ROB_W    = 4;
  localparam int ROB_SIZE = 1 << ROB_W;

  // Issue type encodings; TYPE_RSVD retires like a register write.
  typedef enum logic [1:0] {
    TYPE_REG    = 2'd0,
    TYPE_STORE  = 2'd1,
    TYPE_BRANCH = 2'd2,
    TYPE_RSVD   = 2'd3
  } rob_type_e;

endpackage

// File: rtl/reorder_buffer_if.sv
// Issue / writeback / query / retire bundle between the core and the ROB.
// The slave modport is the reorder buffer's view; master is the core's view.
interface reorder_buffer_if;
  import reorder_buffer_pkg::*;

  logic             issue;
  logic [1:0]       issue_type;
  logic [4:0]       issue_rd;
  logic             issue_pred_taken;
  logic [ROB_W-1:0] issue_rob_pos;
  logic             rob_full;

  logic             alu_valid;
  logic [ROB_W-1:0] alu_rob_pos;
  logic [31:0]      alu_val;
  logic             alu_taken;
  logic [31:0]      alu_pc;

  logic             lsb_valid;
  logic [ROB_W-1:0] lsb_rob_pos;
  logic [31:0]      lsb_val;

  logic [ROB_W-1:0] q1_pos;
  logic             q1_ready;
  logic [31:0]      q1_val;
  logic [ROB_W-1:0] q2_pos;
  logic             q2_ready;
  logic [31:0]      q2_val;

  logic             commit;
  logic [4:0]       commit_rd;
  logic [31:0]      commit_val;
  logic [ROB_W-1:0] commit_rob_pos;
  logic             commit_store;
  logic [ROB_W-1:0] commit_store_pos;
  logic             rollback;
  logic [31:0]      rollback_pc;

  modport slave (
    input  issue, issue_type, issue_rd, issue_pred_taken,
    output issue_rob_pos, rob_full,
    input  alu_valid, alu_rob_pos, alu_val, alu_taken, alu_pc,
    input  lsb_valid, lsb_rob_pos, lsb_val,
    input  q1_pos, q2_pos,
    output q1_ready, q1_val, q2_ready, q2_val,
    output commit, commit_rd, commit_val, commit_rob_pos,
    output commit_store, commit_store_pos, rollback, rollback_pc
  );

  modport master (
    output issue, issue_type, issue_rd, issue_pred_taken,
    input  issue_rob_pos, rob_full,
    output alu_valid, alu_rob_pos, alu_val, alu_taken, alu_pc,
    output lsb_valid, lsb_rob_pos, lsb_val,
    output q1_pos, q2_pos,
    input  q1_ready, q1_val, q2_ready, q2_val,
    input  commit, commit_rd, commit_val, commit_rob_pos,
    input  commit_store, commit_store_pos, rollback, rollback_pc
  );

endinterface

// File: rtl/rob_query_mux.sv
// Operand query port: maps a ROB tag to its ready bit and value.
// With REORDER_BUFFER_FWD_EN defined, a tag matching a writeback strobe in
// the same cycle returns the bus value (ALU has priority over LSB).
module rob_query_mux
  import reorder_buffer_pkg::*;
(
  input  logic [ROB_W-1:0]    q_pos,
  input  logic [ROB_SIZE-1:0] ready_vec,
  input  logic [31:0]         val_arr [ROB_SIZE],
  input  logic                alu_valid,
  input  logic [ROB_W-1:0]    alu_pos,
  input  logic [31:0]         alu_val,
  input  logic                lsb_valid,
  input  logic [ROB_W-1:0]    lsb_pos,
  input  logic [31:0]         lsb_val,
  output logic                q_ready,
  output logic [31:0]         q_val
);

`ifdef REORDER_BUFFER_FWD_EN
  // Stored entry state, overridden by a matching writeback on the buses.
  always_comb begin
    q_ready = ready_vec[q_pos];
    q_val   = val_arr[q_pos];
    if (alu_valid && (alu_pos == q_pos)) begin
      q_ready = 1'b1;
      q_val   = alu_val;
    end else if (lsb_valid && (lsb_pos == q_pos)) begin
      q_ready = 1'b1;
      q_val   = lsb_val;
    end else begin
      q_ready = ready_vec[q_pos];
      q_val   = val_arr[q_pos];
    end
  end
`else
  logic unused_bypass_s;
  assign unused_bypass_s = ^{alu_valid, alu_pos, alu_val, lsb_valid, lsb_pos, lsb_val};

  // Stored entry state only; a writeback becomes visible the next cycle.
  always_comb begin
    q_ready = ready_vec[q_pos];
    q_val   = val_arr[q_pos];
  end
`endif

endmodule

// File: rtl/reorder_buffer.sv
// Reorder buffer: allocates tags at issue, collects ALU/LSB results and
// retires one entry per cycle in program order. Mispredicted branches flush
// the whole buffer. Build option REORDER_BUFFER_FWD_EN enables query bypass.
module reorder_buffer
  import reorder_buffer_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rdy,
  reorder_buffer_if.slave  bus
);

  localparam logic [ROB_W:0] FULL_CNT = (ROB_W + 1)'(ROB_SIZE);

  // Entry storage
  logic [ROB_SIZE-1:0] busy_r;
  logic [ROB_SIZE-1:0] ready_r;
  rob_type_e           type_r [ROB_SIZE];
  logic [4:0]          rd_r   [ROB_SIZE];
  logic [31:0]         val_r  [ROB_SIZE];
  logic [31:0]         pc_r   [ROB_SIZE];
  logic [ROB_SIZE-1:0] pred_r;
  logic [ROB_SIZE-1:0] real_r;

  logic [ROB_W-1:0]    head_r;
  logic [ROB_W-1:0]    tail_r;
  logic [ROB_W:0]      count_r;

  // Registered retire outputs
  logic                commit_r;
  logic [4:0]          commit_rd_r;
  logic [31:0]         commit_val_r;
  logic [ROB_W-1:0]    commit_rob_pos_r;
  logic                commit_store_r;
  logic [ROB_W-1:0]    commit_store_pos_r;
  logic                rollback_r;
  logic [31:0]         rollback_pc_r;

  logic                rob_full_s;
  logic                active_s;
  logic                retire_s;
  logic                mispredict_s;
  logic                do_issue_s;
  logic                do_alu_s;
  logic                do_lsb_s;
  logic                commit_n_s;
  logic                store_n_s;

  assign rob_full_s = (count_r == FULL_CNT);
  // The cycle after a flush ignores all inputs and does not retire.
  assign active_s   = rdy && !rollback_r;
  assign retire_s   = active_s && (count_r != {(ROB_W + 1){1'b0}}) &&
                      busy_r[head_r] && ready_r[head_r];
  assign mispredict_s = retire_s && (type_r[head_r] == TYPE_BRANCH) &&
                        (real_r[head_r] != pred_r[head_r]);
  assign do_issue_s = active_s && !mispredict_s && bus.issue && !rob_full_s;
  assign do_alu_s   = active_s && !mispredict_s && bus.alu_valid && busy_r[bus.alu_rob_pos];
  assign do_lsb_s   = active_s && !mispredict_s && bus.lsb_valid && busy_r[bus.lsb_rob_pos];

  // Decode which retire pulse the head entry produces.
  always_comb begin
    commit_n_s = 1'b0;
    store_n_s  = 1'b0;
    case (type_r[head_r])
      TYPE_REG, TYPE_RSVD: commit_n_s = retire_s;
      TYPE_STORE:          store_n_s  = retire_s;
      TYPE_BRANCH:         commit_n_s = 1'b0;
      default:             commit_n_s = 1'b0;
    endcase
  end

  // Entry array, pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r  <= {ROB_SIZE{1'b0}};
      ready_r <= {ROB_SIZE{1'b0}};
      pred_r  <= {ROB_SIZE{1'b0}};
      real_r  <= {ROB_SIZE{1'b0}};
      for (int i = 0; i < ROB_SIZE; i++) begin
        type_r[i] <= TYPE_REG;
        rd_r[i]   <= 5'd0;
        val_r[i]  <= 32'd0;
        pc_r[i]   <= 32'd0;
      end
      head_r  <= {ROB_W{1'b0}};
      tail_r  <= {ROB_W{1'b0}};
      count_r <= {(ROB_W + 1){1'b0}};
    end else if (mispredict_s) begin
      busy_r  <= {ROB_SIZE{1'b0}};
      head_r  <= {ROB_W{1'b0}};
      tail_r  <= {ROB_W{1'b0}};
      count_r <= {(ROB_W + 1){1'b0}};
    end else begin
      if (do_issue_s) begin
        busy_r[tail_r]  <= 1'b1;
        ready_r[tail_r] <= 1'b0;
        type_r[tail_r]  <= rob_type_e'(bus.issue_type);
        rd_r[tail_r]    <= bus.issue_rd;
        pred_r[tail_r]  <= bus.issue_pred_taken;
        tail_r          <= tail_r + {{(ROB_W - 1){1'b0}}, 1'b1};
      end
      if (do_alu_s) begin
        ready_r[bus.alu_rob_pos] <= 1'b1;
        val_r[bus.alu_rob_pos]   <= bus.alu_val;
        real_r[bus.alu_rob_pos]  <= bus.alu_taken;
        pc_r[bus.alu_rob_pos]    <= bus.alu_pc;
      end
      if (do_lsb_s) begin
        ready_r[bus.lsb_rob_pos] <= 1'b1;
        val_r[bus.lsb_rob_pos]   <= bus.lsb_val;
      end
      if (retire_s) begin
        busy_r[head_r] <= 1'b0;
        head_r         <= head_r + {{(ROB_W - 1){1'b0}}, 1'b1};
      end
      count_r <= count_r + {{ROB_W{1'b0}}, do_issue_s} - {{ROB_W{1'b0}}, retire_s};
    end
  end

  // Retire outputs: one-cycle pulses plus held payload registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      commit_r           <= 1'b0;
      commit_rd_r        <= 5'd0;
      commit_val_r       <= 32'd0;
      commit_rob_pos_r   <= {ROB_W{1'b0}};
      commit_store_r     <= 1'b0;
      commit_store_pos_r <= {ROB_W{1'b0}};
      rollback_r         <= 1'b0;
      rollback_pc_r      <= 32'd0;
    end else begin
      commit_r       <= commit_n_s;
      commit_store_r <= store_n_s;
      rollback_r     <= mispredict_s;
      if (commit_n_s) begin
        commit_rd_r      <= rd_r[head_r];
        commit_val_r     <= val_r[head_r];
        commit_rob_pos_r <= head_r;
      end
      if (store_n_s) begin
        commit_store_pos_r <= head_r;
      end
      if (mispredict_s) begin
        rollback_pc_r <= pc_r[head_r];
      end
    end
  end

  assign bus.issue_rob_pos    = tail_r;
  assign bus.rob_full         = rob_full_s;
  assign bus.commit           = commit_r;
  assign bus.commit_rd        = commit_rd_r;
  assign bus.commit_val       = commit_val_r;
  assign bus.commit_rob_pos   = commit_rob_pos_r;
  assign bus.commit_store     = commit_store_r;
  assign bus.commit_store_pos = commit_store_pos_r;
  assign bus.rollback         = rollback_r;
  assign bus.rollback_pc      = rollback_pc_r;

  rob_query_mux u_q1 (
    .q_pos     (bus.q1_pos),
    .ready_vec (ready_r),
    .val_arr   (val_r),
    .alu_valid (bus.alu_valid),
    .alu_pos   (bus.alu_rob_pos),
    .alu_val   (bus.alu_val),
    .lsb_valid (bus.lsb_valid),
    .lsb_pos   (bus.lsb_rob_pos),
    .lsb_val   (bus.lsb_val),
    .q_ready   (bus.q1_ready),
    .q_val     (bus.q1_val)
  );

  rob_query_mux u_q2 (
    .q_pos     (bus.q2_pos),
    .ready_vec (ready_r),
    .val_arr   (val_r),
    .alu_valid (bus.alu_valid),
    .alu_pos   (bus.alu_rob_pos),
    .alu_val   (bus.alu_val),
    .lsb_valid (bus.lsb_valid),
    .lsb_pos   (bus.lsb_rob_pos),
    .lsb_val   (bus.lsb_val),
    .q_ready   (bus.q2_ready),
    .q_val     (bus.q2_val)
  );

endmodule
